// File: rtl/simul_axi_burst_expand.sv
// AXI3 address-channel burst expander: turns one AxADDR/AxLEN/AxSIZE/AxBURST command
// into one registered beat record per transfer, flagging protocol violations on beat 0.
module simul_axi_burst_expand #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int ID_WIDTH        = 12,
  parameter int DATA_BYTES_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ID_WIDTH-1:0]      cmd_id,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [3:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  input  logic [1:0]               cmd_burst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [ADDRESS_WIDTH-1:0] beat_addr,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic [3:0]               beat_num,
  output logic                     beat_last,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic                     err
);

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {BT_FIXED = 2'd0, BT_INCR = 2'd1, BT_WRAP = 2'd2} burst_e;
  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  localparam logic [2:0] MAX_SIZE = 3'(DATA_BYTES_LOG2);

  state_e            state_q, state_d;
  addr_t             addr_q, addr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [3:0]        num_q, num_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [3:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  burst_e            burst_q, burst_d;
  addr_t             wmask_q, wmask_d;

  // Command decode: effective size/burst and violation flags
  logic   size_bad, rsvd_bad, wlen_bad, walign_bad, page_bad, wrap_len_ok;
  logic [2:0] c_size;
  burst_e c_burst;
  addr_t  c_s, c_wmask, c_last;

  always_comb begin
    size_bad    = cmd_size > MAX_SIZE;
    c_size      = size_bad ? MAX_SIZE : cmd_size;
    c_s         = addr_t'(1) << c_size;
    wrap_len_ok = cmd_len inside {4'd1, 4'd3, 4'd7, 4'd15};
    rsvd_bad    = cmd_burst == 2'd3;
    wlen_bad    = (cmd_burst == 2'd2) && !wrap_len_ok;
    c_burst     = BT_INCR;
    case (cmd_burst)
      2'd0:    c_burst = BT_FIXED;
      2'd2:    c_burst = wrap_len_ok ? BT_WRAP : BT_INCR;
      default: c_burst = BT_INCR;
    endcase
    walign_bad = (c_burst == BT_WRAP) && ((cmd_addr & (c_s - addr_t'(1))) != '0);
    c_wmask    = ((addr_t'(cmd_len) + addr_t'(1)) << c_size) - addr_t'(1);
    // Final INCR beat: beats after the first sit on S-aligned slots
    c_last     = (cmd_len == 4'd0) ? cmd_addr
               : (cmd_addr & ~(c_s - addr_t'(1))) + (addr_t'(cmd_len) << c_size);
    page_bad   = (c_burst == BT_INCR) && ((c_last >> 12) != (cmd_addr >> 12));
  end

  // Next beat address from the latched burst parameters
  addr_t s_cur, a_al, nxt_addr;

  always_comb begin
    s_cur = addr_t'(1) << size_q;
    a_al  = addr_q & ~(s_cur - addr_t'(1));
    case (burst_q)
      BT_FIXED: nxt_addr = addr_q;
      BT_WRAP:  nxt_addr = (a_al & ~wmask_q) | ((a_al + s_cur) & wmask_q);
      default:  nxt_addr = a_al + s_cur;
    endcase
  end

  assign beat_valid = (state_q == S_BURST);
  assign cmd_ready  = !beat_valid || (beat_ready && last_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    num_d   = num_q;
    last_d  = last_q;
    err_d   = 1'b0;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    wmask_d = wmask_q;

    if (state_q == S_BURST && beat_ready) begin
      if (!last_q) begin
        num_d  = num_q + 4'd1;
        last_d = (num_q + 4'd1) == len_q;
        addr_d = nxt_addr;
      end else begin
        state_d = S_IDLE;
      end
    end

    // A load overrides the burst-end return to IDLE, giving bubble-free back-to-back bursts
    if (cmd_valid && cmd_ready) begin
      state_d = S_BURST;
      addr_d  = cmd_addr;
      id_d    = cmd_id;
      num_d   = 4'd0;
      last_d  = cmd_len == 4'd0;
      len_d   = cmd_len;
      size_d  = c_size;
      burst_d = c_burst;
      wmask_d = c_wmask;
      err_d   = size_bad | rsvd_bad | wlen_bad | walign_bad | page_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      num_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BT_FIXED;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      num_q   <= num_d;
      last_q  <= last_d;
      err_q   <= err_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      wmask_q <= wmask_d;
    end
  end

  assign beat_addr = addr_q;
  assign beat_id   = id_q;
  assign beat_num  = num_q;
  assign beat_last = last_q;
  assign err       = err_q;

endmodule
